skid_pipe_reg: RTL and testbench

//  Two-entry valid/ready skid buffer: the consumer-side counterpart to our enable-gated register walls.

---
 rtl/skid_pkg.sv | 20 ++
 rtl/skid_data_reg.sv | 21 ++
 rtl/skid_pipe_reg.sv | 112 +++++++++++
 tb/tb_skid_pipe_reg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// Shared types for the two-entry skid buffer: FSM state encoding and occupancy mapping.
package skid_pkg;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'b00,
        SK_ONE   = 2'b01,
        SK_TWO   = 2'b11
    } skid_state_e;

    localparam int SK_CNT_W = 2;

    function automatic logic [SK_CNT_W-1:0] state_count(input skid_state_e s);
        case (s)
            SK_ONE:  return 2'd1;
            SK_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_data_reg.sv
// WIDTH-bit payload register with synchronous active-high clear and load enable.
module skid_data_reg #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset)   data_q <= '0;
        else if (en) data_q <= d;
    end

    assign q = data_q;

endmodule

// File: rtl/skid_pipe_reg.sv
// Two-entry valid/ready skid buffer with registered in_ready.
// Optional SKID_FLUSH_EN adds a flush input that empties the buffer.
module skid_pipe_reg
    import skid_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    input  logic                out_ready,
`ifdef SKID_FLUSH_EN
    input  logic                flush,
`endif
    output logic [SK_CNT_W-1:0] count
);

    skid_state_e         state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [SK_CNT_W-1:0] count_q, count_d;
    logic                in_fire, out_fire, do_flush;
    logic                main_en, skid_en;
    logic [WIDTH-1:0]    main_d, main_q, skid_q;

`ifdef SKID_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    assign out_valid = (state_q != SK_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        case (state_q)
            SK_EMPTY: begin
                if (in_fire) begin
                    state_d = SK_ONE;
                    main_en = 1'b1;
                end
            end
            SK_ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = SK_TWO;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = SK_EMPTY;
                end
            end
            SK_TWO: begin
                // in_ready is low here, so only the drain side can move
                if (out_fire) begin
                    state_d = SK_ONE;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = SK_EMPTY;
        endcase
        if (do_flush) begin
            state_d = SK_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
        in_ready_d = (state_d != SK_TWO);
        count_d    = state_count(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SK_EMPTY;
            in_ready_q <= 1'b1;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
        end
    end

    skid_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    skid_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

    assign in_ready = in_ready_q;
    assign out_data = main_q;
    assign count    = count_q;

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Self-checking bench for skid_pipe_reg: directed vector table, hand sequences, and
// randomized traffic against a queue-based reference model.
module tb_skid_pipe_reg;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready, flush;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] mdl_q[$];

    always #5 clk = ~clk;

    skid_pipe_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef SKID_FLUSH_EN
        .flush     (flush),
`endif
        .count     (count)
    );

    typedef struct {
        logic         rst;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         ev;
        logic [W-1:0] ed;
        logic         chkd;
        logic [1:0]   ec;
        logic         er;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [W-1:0] d,
                                input logic ordy, input logic ev, input logic [W-1:0] ed,
                                input logic chkd, input logic [1:0] ec, input logic er);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.chkd = chkd; v.ec = ec; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle; the model advances on the same edge using the occupancy rules.
    task automatic step(input logic rst, input logic iv, input logic [W-1:0] d,
                        input logic ordy, input logic fl);
        bit ofire, ifire;
        reset = rst; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        @(posedge clk);
        ofire = (mdl_q.size() > 0) && ordy;
        ifire = iv && (mdl_q.size() < 2);
`ifndef SKID_FLUSH_EN
        fl = 1'b0;
`endif
        if (rst || fl) begin
            mdl_q.delete();
        end else begin
            if (ofire) void'(mdl_q.pop_front());
            if (ifire) mdl_q.push_back(d);
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(mdl_q.size() > 0));
        chk({tag, ".count"}, 32'(count), 32'(mdl_q.size()));
        chk({tag, ".ready"}, 32'(in_ready), 32'(mdl_q.size() < 2));
        if (mdl_q.size() > 0) chk({tag, ".data"}, 32'(out_data), 32'(mdl_q[0]));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

        //               rst   iv    data    ordy  ev    edata   chkd  cnt    rdy
        vecs[0]  = mk(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 2'd0, 1'b1);
        vecs[1]  = mk(1'b0, 1'b1, 10'h155, 1'b1, 1'b1, 10'h155, 1'b1, 2'd1, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 2'd0, 1'b1);
        vecs[3]  = mk(1'b0, 1'b1, 10'h0AA, 1'b0, 1'b1, 10'h0AA, 1'b1, 2'd1, 1'b1);
        vecs[4]  = mk(1'b0, 1'b1, 10'h0BB, 1'b0, 1'b1, 10'h0AA, 1'b1, 2'd2, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 10'h0CC, 1'b0, 1'b1, 10'h0AA, 1'b1, 2'd2, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h0BB, 1'b1, 2'd1, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 2'd0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b1, 10'h011, 1'b0, 1'b1, 10'h011, 1'b1, 2'd1, 1'b1);
        vecs[9]  = mk(1'b0, 1'b1, 10'h022, 1'b0, 1'b1, 10'h011, 1'b1, 2'd2, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 10'h033, 1'b1, 1'b0, 10'h000, 1'b1, 2'd0, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 2'd0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].ec));
            chk($sformatf("vec%0d.ready", i), 32'(in_ready), 32'(vecs[i].er));
            if (vecs[i].chkd) chk($sformatf("vec%0d.data", i), 32'(out_data), 32'(vecs[i].ed));
        end

        // Full-throughput stream: one word per cycle, never back-pressured.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, W'(i), 1'b1, 1'b0);
            chk($sformatf("stream%0d.data", i), 32'(out_data), 32'(i));
            chk($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d.ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("stream_drain.valid", 32'(out_valid), 32'd0);

`ifdef SKID_FLUSH_EN
        step(1'b0, 1'b1, 10'h101, 1'b0, 1'b0);
        step(1'b0, 1'b1, 10'h202, 1'b0, 1'b0);
        chk("flush_fill.count", 32'(count), 32'd2);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 10'h3FF, 1'b1, 1'b1);
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.ready", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 10'h3FF, 1'b0, 1'b1);
        chk("flush_hs.count", 32'(count), 32'd0);
        step(1'b0, 1'b1, 10'h0F0, 1'b1, 1'b0);
        chk("post_flush.data", 32'(out_data), 32'h0F0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("post_flush.valid", 32'(out_valid), 32'd0);
        // reset must win over a simultaneous flush and still clear data
        step(1'b0, 1'b1, 10'h0A5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 10'h05A, 1'b0, 1'b1);
        chk("rst_flush.data", 32'(out_data), 32'd0);
        chk("rst_flush.count", 32'(count), 32'd0);
`endif

        // Random traffic against the queue model; occasional reset (and flush when built in).
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk_model("rnd_init");
        for (int c = 0; c < 10000; c++) begin
            logic rr, ff;
            rr = ($urandom_range(0, 499) == 0);
`ifdef SKID_FLUSH_EN
            ff = ($urandom_range(0, 99) == 0);
`else
            ff = 1'b0;
`endif
            step(rr, ($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0), ff);
            chk_model($sformatf("rnd%0d", c));
            if (rr) chk($sformatf("rnd%0d.rstdata", c), 32'(out_data), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
